decimal_key_bcd_encoder: RTL and testbench

DECIMAL_KEY_BCD_ENCODER -- requirements
Module: decimal_key_bcd_encoder

---
 rtl/decimal_key_bcd_encoder_pkg.sv | 23 ++
 rtl/decimal_key_bcd_encoder_key_sync_2ff.sv | 41 ++++
 rtl/decimal_key_bcd_encoder.sv | 187 ++++++++++++++++++
 tb/tb_decimal_key_bcd_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_key_bcd_encoder_pkg.sv
// -----------------------------------------------------------------------------
// decimal_key_bcd_encoder_pkg
//
// Shared definitions for the decimal keypad encoder:
//   - BCD_W      : width of the BCD digit code (4)
//   - KEY_COUNT  : number of decimal key lines (10, bit k = digit k)
//   - CNT_W      : width of the debounce / release counter (8)
//   - state_t    : encoder FSM state encoding
// -----------------------------------------------------------------------------
package decimal_key_bcd_encoder_pkg;

  localparam int BCD_W     = 4;
  localparam int KEY_COUNT = 10;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,  // waiting for a key press
    ST_DEBOUNCE     = 2'd1,  // single key seen, counting stable cycles
    ST_OUTPUT       = 2'd2,  // digit presented, waiting for the consumer
    ST_WAIT_RELEASE = 2'd3   // waiting for all keys released and stable
  } state_t;

endpackage : decimal_key_bcd_encoder_pkg

// File: rtl/decimal_key_bcd_encoder_key_sync_2ff.sv
// -----------------------------------------------------------------------------
// key_sync_2ff
//
// Parameterized-width two-flop synchronizer for quasi-static inputs that are
// asynchronous to clk. Each bit is synchronized independently; a bit changing
// near the clock edge may land one cycle later than its neighbours, which the
// downstream debounce logic tolerates.
//
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset, clears both flop stages
//   d      in   [WIDTH-1:0] asynchronous input vector
//   q      out  [WIDTH-1:0] synchronized vector (two clk edges of latency)
// -----------------------------------------------------------------------------
module key_sync_2ff #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state is written with non-blocking assignments so that
  // sync_q picks up the previous meta_q value, forming a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : key_sync_2ff

// File: rtl/decimal_key_bcd_encoder.sv
// -----------------------------------------------------------------------------
// decimal_key_bcd_encoder
//
// Debounced encoder for a 10-line decimal keypad. A single key held stable
// for DEBOUNCE_CYCLES synchronized cycles is converted to its BCD digit and
// presented with a valid/ready handshake. Simultaneous presses raise a
// one-cycle multi_err pulse. After each press (accepted or rejected as
// multiple) all keys must read released for DEBOUNCE_CYCLES consecutive
// cycles before a new press is considered.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or a release,
//                    legal range 1..255
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset (deassertion synchronized
//                   externally)
//   key_in     in   [9:0] raw active-high key lines, asynchronous to clk
//   bcd_out    out  [3:0] last accepted digit (0..9), held after valid clears
//   bcd_valid  out  bcd_out holds a digit not yet taken by the consumer
//   bcd_ready  in   consumer takes the digit on an edge where bcd_valid=1
//   multi_err  out  one-cycle pulse: several keys seen at press start
//   busy       out  encoder FSM is not idle
// -----------------------------------------------------------------------------
module decimal_key_bcd_encoder
  import decimal_key_bcd_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_COUNT-1:0] key_in,
  output logic [BCD_W-1:0]     bcd_out,
  output logic                 bcd_valid,
  input  logic                 bcd_ready,
  output logic                 multi_err,
  output logic                 busy
);

  // Terminal count shared by the press debounce and the release window.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // One-hot key vector to BCD index. Only called on a vector already known to
  // be one-hot, so the highest set bit is the digit.
  // ---------------------------------------------------------------------------
  function automatic logic [BCD_W-1:0] onehot_to_bcd(
    input logic [KEY_COUNT-1:0] keys
  );
    logic [BCD_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (keys[i]) idx = BCD_W'(i);
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic [KEY_COUNT-1:0] sync_keys;

  key_sync_2ff #(
    .WIDTH (KEY_COUNT)
  ) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (sync_keys)
  );

  // Exactly-one / any-key decode of the synchronized vector. Clearing the
  // lowest set bit leaves zero only when a single bit was set.
  logic key_any;
  logic key_one;

  assign key_any = |sync_keys;
  assign key_one = key_any &&
                   ((sync_keys & (sync_keys - KEY_COUNT'(1))) == '0);

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  state_t               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [KEY_COUNT-1:0] captured_q,  captured_d;
  logic [BCD_W-1:0]     bcd_out_q,   bcd_out_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic                 multi_err_q, multi_err_d;

  // NOTE: every register here is a plain flop (no memory arrays), so all of
  // them are cleared by the asynchronous reset; a reset mid-press therefore
  // discards any captured key or pending digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      captured_q  <= '0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
      multi_err_q <= multi_err_d;
    end
  end

  // NOTE: each signal driven here gets a default before the case statement so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    captured_d  = captured_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = bcd_valid_q;
    multi_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (key_one) begin
          captured_d = sync_keys;
          state_d    = ST_DEBOUNCE;
        end else if (key_any) begin
          // Two or more keys at press start: flag once, then wait them out.
          multi_err_d = 1'b1;
          state_d     = ST_WAIT_RELEASE;
        end
      end

      ST_DEBOUNCE: begin
        if (sync_keys != captured_q) begin
          // Bounce, release or extra key before the press is stable: drop it
          // silently and start over.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          bcd_out_d   = onehot_to_bcd(captured_q);
          bcd_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_OUTPUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_OUTPUT: begin
        // The digit is committed: key activity is ignored until it is taken.
        if (bcd_ready) begin
          bcd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT_RELEASE;
        end
      end

      ST_WAIT_RELEASE: begin
        if (key_any) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;
  assign multi_err = multi_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule : decimal_key_bcd_encoder

// File: tb/tb_decimal_key_bcd_encoder.sv
// -----------------------------------------------------------------------------
// tb_decimal_key_bcd_encoder
//
// Two encoders (DEBOUNCE_CYCLES = 4 and 1) share one key/ready/reset stimulus.
// Directed steps exercise the documented scenarios; a randomized phase then
// applies random key patterns and hold lengths with a random ready, and the
// observed transfers and error pulses are compared with a press-level model:
// a single key held for at least D+1 sampled cycles yields exactly one digit,
// a multi-key press yields exactly one multi_err pulse and no digit.
// -----------------------------------------------------------------------------
module tb_decimal_key_bcd_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_in;
  logic       bcd_ready;

  logic [3:0] out4, out1;
  logic       valid4, valid1;
  logic       merr4, merr1;
  logic       busy4, busy1;

  always #5 clk = ~clk;

  decimal_key_bcd_encoder #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .bcd_out   (out4),
    .bcd_valid (valid4),
    .bcd_ready (bcd_ready),
    .multi_err (merr4),
    .busy      (busy4)
  );

  decimal_key_bcd_encoder #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .bcd_out   (out1),
    .bcd_valid (valid1),
    .bcd_ready (bcd_ready),
    .multi_err (merr1),
    .busy      (busy1)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Event monitors: cumulative transfer / error / valid-cycle counts and
  // stability violations (valid dropped or digit changed while not taken).
  // ---------------------------------------------------------------------------
  int xfer4 = 0, xfer1 = 0, mcnt4 = 0, mcnt1 = 0, vcyc4 = 0, vcyc1 = 0;
  int unstable4 = 0, unstable1 = 0;
  int xq4[$];
  int xq1[$];
  logic       pv4 = 1'b0, pv1 = 1'b0, pr4 = 1'b0, pr1 = 1'b0;
  logic [3:0] po4 = '0, po1 = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pv4 <= 1'b0;
    end else begin
      if (pv4 && !pr4 && (!valid4 || out4 != po4)) unstable4 <= unstable4 + 1;
      if (valid4 && bcd_ready) begin
        xfer4 <= xfer4 + 1;
        xq4.push_back(int'(out4));
      end
      if (merr4)  mcnt4 <= mcnt4 + 1;
      if (valid4) vcyc4 <= vcyc4 + 1;
      pv4 <= valid4;
      po4 <= out4;
      pr4 <= bcd_ready;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      pv1 <= 1'b0;
    end else begin
      if (pv1 && !pr1 && (!valid1 || out1 != po1)) unstable1 <= unstable1 + 1;
      if (valid1 && bcd_ready) begin
        xfer1 <= xfer1 + 1;
        xq1.push_back(int'(out1));
      end
      if (merr1)  mcnt1 <= mcnt1 + 1;
      if (valid1) vcyc1 <= vcyc1 + 1;
      pv1 <= valid1;
      po1 <= out1;
      pr1 <= bcd_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Press-level reference model
  // ---------------------------------------------------------------------------
  function automatic int ones(input logic [9:0] p);
    int n = 0;
    for (int i = 0; i < 10; i++) if (p[i]) n++;
    return n;
  endfunction

  function automatic int digit_of(input logic [9:0] p);
    int d = -1;
    for (int i = 0; i < 10; i++) if (p[i]) d = i;
    return d;
  endfunction

  // Digits produced by one press of pattern p held for l sampled cycles.
  function automatic int model_xfers(input logic [9:0] p, input int l,
                                     input int d);
    return (ones(p) == 1 && l >= d + 1) ? 1 : 0;
  endfunction

  function automatic int model_merrs(input logic [9:0] p);
    return (ones(p) >= 2) ? 1 : 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Let the synchronizer drain, then wait (bounded) for both encoders idle.
  task automatic wait_idle(input string tag, input bit rnd_ready);
    int n = 0;
    tick(3);
    while ((busy4 || busy1) && n < 300) begin
      if (rnd_ready) bcd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk({tag, "_idle_bound"}, 32'(n < 300), 32'd1);
    tick(2);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int b_x, b_m, b_v, b_u, b_q;
  logic [9:0] pat;
  int hold, ex, em;

  initial begin
    rst_n     = 1'b0;
    key_in    = '0;
    bcd_ready = 1'b0;
    tick(2);

    // Reset state
    chk("rst_valid4", valid4, 0);
    chk("rst_out4",   out4,   0);
    chk("rst_merr4",  merr4,  0);
    chk("rst_busy4",  busy4,  0);
    chk("rst_valid1", valid1, 0);
    rst_n = 1'b1;
    tick(2);

    // Key 5 held 20 cycles, ready high throughout
    b_x = xfer4; b_v = vcyc4;
    bcd_ready = 1'b1;
    key_in    = 10'b0000100000;
    tick(6);
    chk("k5_valid_e6", valid4, 0);
    tick(1);
    chk("k5_valid_e7", valid4, 1);
    chk("k5_out_e7",   out4,   5);
    chk("k5_merr_e7",  merr4,  0);
    tick(1);
    chk("k5_valid_e8", valid4, 0);
    chk("k5_out_hold", out4,   5);
    chk("k5_busy_e8",  busy4,  1);
    tick(12);
    key_in = '0;
    tick(5);
    chk("k5_busy_rel4", busy4, 1);
    tick(1);
    chk("k5_busy_rel5", busy4, 0);
    chk("k5_xfers",     xfer4 - b_x, 1);
    chk("k5_vcycles",   vcyc4 - b_v, 1);
    wait_idle("k5", 1'b0);

    // Key 3 with ready low, released while the digit is pending
    b_x = xfer4; b_v = vcyc4; b_u = unstable4;
    bcd_ready = 1'b0;
    key_in    = 10'b0000001000;
    tick(7);
    chk("k3_valid_e7", valid4, 1);
    chk("k3_out_e7",   out4,   3);
    tick(1);
    key_in = '0;
    tick(2);
    chk("k3_valid_e10", valid4, 1);
    chk("k3_out_e10",   out4,   3);
    bcd_ready = 1'b1;
    tick(1);
    chk("k3_valid_e11", valid4, 0);
    wait_idle("k3", 1'b0);
    chk("k3_xfers",    xfer4 - b_x, 1);
    chk("k3_digit",    xq4[$],      3);
    chk("k3_vcycles",  vcyc4 - b_v, 4);
    chk("k3_unstable", unstable4 - b_u, 0);

    // Key 7 glitch, three synchronized cycles
    b_x = xfer4; b_v = vcyc4; b_m = mcnt4;
    key_in = 10'b0010000000;
    tick(3);
    key_in = '0;
    tick(2);
    chk("k7_busy_deb",  busy4, 1);
    tick(1);
    chk("k7_busy_idle", busy4, 0);
    wait_idle("k7", 1'b0);
    chk("k7_vcycles", vcyc4 - b_v, 0);
    chk("k7_merrs",   mcnt4 - b_m, 0);

    // Two keys together, then a normal press of key 4
    b_x = xfer4; b_v = vcyc4; b_m = mcnt4;
    key_in = 10'b0000000011;
    tick(2);
    chk("mk_merr_e2",  merr4,  0);
    tick(1);
    chk("mk_merr_e3",  merr4,  1);
    chk("mk_busy_e3",  busy4,  1);
    chk("mk_valid_e3", valid4, 0);
    tick(1);
    chk("mk_merr_e4",  merr4,  0);
    tick(3);
    key_in = '0;
    wait_idle("mk", 1'b0);
    chk("mk_merrs",   mcnt4 - b_m, 1);
    chk("mk_vcycles", vcyc4 - b_v, 0);
    key_in = 10'b0000010000;
    tick(10);
    key_in = '0;
    wait_idle("mk4", 1'b0);
    chk("mk4_xfers", xfer4 - b_x, 1);
    chk("mk4_digit", xq4[$],      4);

    // Reset while digit 9 is pending, key kept held
    b_x = xfer4;
    bcd_ready = 1'b0;
    key_in    = 10'b1000000000;
    tick(7);
    chk("r9_valid_pre", valid4, 1);
    chk("r9_out_pre",   out4,   9);
    rst_n = 1'b0;
    #1;
    chk("r9_valid_rst", valid4, 0);
    chk("r9_out_rst",   out4,   0);
    chk("r9_busy_rst",  busy4,  0);
    chk("r9_valid1_rst", valid1, 0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("r9_valid_e6", valid4, 0);
    tick(1);
    chk("r9_valid_e7", valid4, 1);
    chk("r9_out_e7",   out4,   9);
    bcd_ready = 1'b1;
    tick(1);
    key_in = '0;
    wait_idle("r9", 1'b0);
    chk("r9_xfers", xfer4 - b_x, 1);

    // D=1: every key in turn, short holds (too short for D=4)
    b_x = xfer4; b_q = xq1.size();
    bcd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      key_in = 10'(1 << k);
      tick(4);
      key_in = '0;
      wait_idle("seq", 1'b0);
    end
    chk("seq_count", xq1.size() - b_q, 10);
    for (int k = 0; k < 10; k++) begin
      if (b_q + k < xq1.size()) chk($sformatf("seq_digit%0d", k), xq1[b_q + k], k);
    end
    chk("seq_d4_none", xfer4 - b_x, 0);

    // Randomized presses against the press-level model
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        pat = 10'(1 << $urandom_range(0, 9));
      end else begin
        pat = 10'($urandom);
        while (ones(pat) < 2) pat = 10'($urandom);
      end
      hold = $urandom_range(1, 9);
      b_x = xfer4; b_m = mcnt4; b_q = xfer1; b_v = mcnt1;
      key_in = pat;
      for (int c = 0; c < hold; c++) begin
        bcd_ready = 1'($urandom_range(0, 1));
        tick();
      end
      key_in = '0;
      wait_idle($sformatf("rnd%0d", t), 1'b1);

      ex = model_xfers(pat, hold, 4);
      em = model_merrs(pat);
      chk($sformatf("rnd%0d_x4", t), xfer4 - b_x, ex);
      chk($sformatf("rnd%0d_m4", t), mcnt4 - b_m, em);
      if (ex == 1 && xfer4 - b_x == 1)
        chk($sformatf("rnd%0d_d4", t), xq4[$], digit_of(pat));
      ex = model_xfers(pat, hold, 1);
      chk($sformatf("rnd%0d_x1", t), xfer1 - b_q, ex);
      chk($sformatf("rnd%0d_m1", t), mcnt1 - b_v, em);
      if (ex == 1 && xfer1 - b_q == 1)
        chk($sformatf("rnd%0d_d1", t), xq1[$], digit_of(pat));
    end

    chk("stable_d4", unstable4, 0);
    chk("stable_d1", unstable1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decimal_key_bcd_encoder
